// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/stall control
// and a saturating count of inserted bubbles.
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [7:0]  Control_i,
    input  logic [31:0] RS1data_i,
    input  logic [31:0] RS2data_i,
    input  logic [31:0] SignExt_i,
    input  logic [4:0]  RSaddr_i,
    input  logic [4:0]  RTaddr_i,
    input  logic [4:0]  RDaddr_i,
    input  logic [5:0]  Funct_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    output logic [7:0]  Control_o,
    output logic [31:0] RS1data_o,
    output logic [31:0] RS2data_o,
    output logic [31:0] SignExt_o,
    output logic [4:0]  RSaddr_o,
    output logic [4:0]  RTaddr_o,
    output logic [4:0]  RDaddr_o,
    output logic [5:0]  Funct_o,
    output logic        HazardStall_o,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic [15:0] BubbleCnt_o
);

    localparam int unsigned CTRL_W    = 8;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MEM_READ  = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic bubble_c;
    logic rt_nonzero_c;
    logic rt_match_c;

    // Load in EX whose destination is read by the instruction now in ID.
    always_comb begin
        rt_nonzero_c  = (RTaddr_o != 5'd0);
        rt_match_c    = (RTaddr_o == RSaddr_i) || (RTaddr_o == RTaddr_i);
        HazardStall_o = Control_o[MEM_READ] && rt_nonzero_c && rt_match_c;
        PCWrite_o     = ~HazardStall_o;
        IFIDWrite_o   = ~HazardStall_o;
        bubble_c      = Flush_i || HazardStall_o;
    end

    // Stall freezes everything; a bubble only zeroes the control word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            Control_o <= '0;
            RS1data_o <= '0;
            RS2data_o <= '0;
            SignExt_o <= '0;
            RSaddr_o  <= '0;
            RTaddr_o  <= '0;
            RDaddr_o  <= '0;
            Funct_o   <= '0;
        end else if (!Stall_i) begin
            Control_o <= bubble_c ? CTRL_W'(0) : Control_i;
            RS1data_o <= RS1data_i;
            RS2data_o <= RS2data_i;
            SignExt_o <= SignExt_i;
            RSaddr_o  <= RSaddr_i;
            RTaddr_o  <= RTaddr_i;
            RDaddr_o  <= RDaddr_i;
            Funct_o   <= Funct_i;
        end
    end

    // One count per bubble edge, regardless of how many causes coincide.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            BubbleCnt_o <= '0;
        end else if (!Stall_i && bubble_c && (BubbleCnt_o != CNT_MAX)) begin
            BubbleCnt_o <= BubbleCnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [7:0]  Control_i;
    logic [31:0] RS1data_i, RS2data_i, SignExt_i;
    logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
    logic [5:0]  Funct_i;
    logic        Stall_i, Flush_i;
    logic [7:0]  Control_o;
    logic [31:0] RS1data_o, RS2data_o, SignExt_o;
    logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o;
    logic [5:0]  Funct_o;
    logic        HazardStall_o, PCWrite_o, IFIDWrite_o;
    logic [15:0] BubbleCnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .Control_i(Control_i), .RS1data_i(RS1data_i), .RS2data_i(RS2data_i),
        .SignExt_i(SignExt_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
        .RDaddr_i(RDaddr_i), .Funct_i(Funct_i), .Stall_i(Stall_i), .Flush_i(Flush_i),
        .Control_o(Control_o), .RS1data_o(RS1data_o), .RS2data_o(RS2data_o),
        .SignExt_o(SignExt_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o),
        .RDaddr_o(RDaddr_o), .Funct_o(Funct_o), .HazardStall_o(HazardStall_o),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .BubbleCnt_o(BubbleCnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i   = 1'b0;
        Control_i = 8'h00; RS1data_i = '0; RS2data_i = '0; SignExt_i = '0;
        RSaddr_i  = '0; RTaddr_i = '0; RDaddr_i = '0; Funct_i = '0;
        Stall_i   = 1'b0; Flush_i = 1'b0;

        // Reset state
        #3;
        check("rst_ctrl", 32'(Control_o), 32'h0);
        check("rst_cnt", 32'(BubbleCnt_o), 32'h0);
        check("rst_haz", 32'(HazardStall_o), 32'h0);
        check("rst_pcw", 32'(PCWrite_o), 32'h1);
        check("rst_ifidw", 32'(IFIDWrite_o), 32'h1);
        #9 rst_n_i = 1'b1;

        // Normal load, first edge after reset
        Control_i = 8'h81; RS1data_i = 32'h5; RS2data_i = 32'hA5A5_0001; SignExt_i = 32'hFFFF_FFF0;
        RSaddr_i = 5'd4; RTaddr_i = 5'd6; RDaddr_i = 5'd3; Funct_i = 6'h20;
        step();
        check("nl_ctrl", 32'(Control_o), 32'h81);
        check("nl_rs1", RS1data_o, 32'h5);
        check("nl_rs2", RS2data_o, 32'hA5A5_0001);
        check("nl_sext", SignExt_o, 32'hFFFF_FFF0);
        check("nl_rs", 32'(RSaddr_o), 32'd4);
        check("nl_rt", 32'(RTaddr_o), 32'd6);
        check("nl_rd", 32'(RDaddr_o), 32'd3);
        check("nl_funct", 32'(Funct_o), 32'h20);
        check("nl_haz", 32'(HazardStall_o), 32'h0);

        // Load-use hazard on RS
        Control_i = 8'h17; RSaddr_i = 5'd1; RTaddr_i = 5'd8;
        step();
        Control_i = 8'h01; RSaddr_i = 5'd8; RTaddr_i = 5'd2;
        #1;
        check("lu_haz", 32'(HazardStall_o), 32'h1);
        check("lu_pcw", 32'(PCWrite_o), 32'h0);
        check("lu_ifidw", 32'(IFIDWrite_o), 32'h0);
        step();
        check("lu_bub_ctrl", 32'(Control_o), 32'h0);
        check("lu_bub_cnt", 32'(BubbleCnt_o), 32'd1);
        check("lu_bub_rt", 32'(RTaddr_o), 32'd2);
        check("lu_clear", 32'(HazardStall_o), 32'h0);
        step();
        check("lu_resume", 32'(Control_o), 32'h01);
        check("lu_cnt_hold", 32'(BubbleCnt_o), 32'd1);

        // Load-use hazard on RT
        Control_i = 8'h17; RSaddr_i = 5'd3; RTaddr_i = 5'd9;
        step();
        Control_i = 8'h01; RSaddr_i = 5'd3; RTaddr_i = 5'd9;
        #1;
        check("rt_haz", 32'(HazardStall_o), 32'h1);
        step();
        check("rt_cnt", 32'(BubbleCnt_o), 32'd2);

        // $0 destination never stalls
        Control_i = 8'h17; RSaddr_i = 5'd5; RTaddr_i = 5'd0;
        step();
        Control_i = 8'h01; RSaddr_i = 5'd0; RTaddr_i = 5'd0;
        #1;
        check("z_haz", 32'(HazardStall_o), 32'h0);
        step();
        check("z_ctrl", 32'(Control_o), 32'h01);
        check("z_cnt", 32'(BubbleCnt_o), 32'd2);

        // Stall outranks flush and hazard
        Control_i = 8'h17; RS1data_i = 32'h1234; RSaddr_i = 5'd1; RTaddr_i = 5'd8;
        step();
        Stall_i = 1'b1; Flush_i = 1'b1; Control_i = 8'h55; RS1data_i = 32'hDEAD_BEEF; RSaddr_i = 5'd8;
        #1;
        check("st_haz", 32'(HazardStall_o), 32'h1);
        repeat (3) step();
        check("st_ctrl", 32'(Control_o), 32'h17);
        check("st_rs1", RS1data_o, 32'h1234);
        check("st_cnt", 32'(BubbleCnt_o), 32'd2);
        Stall_i = 1'b0;
        step();
        check("st_rel_ctrl", 32'(Control_o), 32'h0);
        check("st_rel_cnt", 32'(BubbleCnt_o), 32'd3);
        check("st_rel_rs1", RS1data_o, 32'hDEAD_BEEF);

        // Async reset between edges, with a stall pending
        Flush_i = 1'b0; Control_i = 8'h81; RS1data_i = 32'h77;
        step();
        check("ar_pre", 32'(Control_o), 32'h81);
        Stall_i = 1'b1;
        #2 rst_n_i = 1'b0;
        #1;
        check("ar_ctrl", 32'(Control_o), 32'h0);
        check("ar_cnt", 32'(BubbleCnt_o), 32'h0);
        check("ar_rs1", RS1data_o, 32'h0);
        check("ar_pcw", 32'(PCWrite_o), 32'h1);
        step();
        Stall_i = 1'b0;
        #2 rst_n_i = 1'b1;
        step();
        check("ar_first", 32'(Control_o), 32'h81);
        check("ar_first_rs1", RS1data_o, 32'h77);

        // Saturation: flush up to FFFE, then past the top
        Flush_i = 1'b1;
        repeat (65534) @(posedge clk_i);
        #1;
        check("sat_pre", 32'(BubbleCnt_o), 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sat_cnt", 32'(BubbleCnt_o), 32'hFFFF);
        end
        check("sat_ctrl", 32'(Control_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL expose clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 The block SHALL expose rst_n_i, input, 1, an asynchronous active-low reset.
REQ-003 The block SHALL expose Control_i, input, 8, ID-stage control bits:
  - [0] RegWrite, [1] MemtoReg, [2] MemRead, [3] MemWrite, [4] ALUSrc, [6:5] ALUOp, [7] RegDst.
REQ-004 The block SHALL expose RS1data_i and RS2data_i, input, 32 each, register-file read data.
REQ-005 The block SHALL expose SignExt_i, input, 32, the sign-extended immediate.
REQ-006 The block SHALL expose RSaddr_i, RTaddr_i and RDaddr_i, input, 5 each, instruction register fields.
REQ-007 The block SHALL expose Funct_i, input, 6, the instruction funct field.
REQ-008 The block SHALL expose Stall_i, input, 1, a global hold that freezes all state.
REQ-009 The block SHALL expose Flush_i, input, 1, which forces a bubble into EX (taken branch or jump).
REQ-010 The block SHALL expose registered outputs Control_o (8), RS1data_o (32), RS2data_o (32), SignExt_o (32), RSaddr_o (5), RTaddr_o (5), RDaddr_o (5) and Funct_o (6), all EX-stage copies.
REQ-011 The block SHALL expose HazardStall_o, output, 1, a combinational load-use hazard indicator.
REQ-012 The block SHALL expose PCWrite_o and IFIDWrite_o, output, 1 each, both equal to ~HazardStall_o.
REQ-013 The block SHALL expose BubbleCnt_o, output, 16, the count of inserted bubbles.

Function
REQ-014 HazardStall_o SHALL be asserted when all of the following hold:
  - Control_o[2] = 1;
  - RTaddr_o != 0;
  - RTaddr_o == RSaddr_i or RTaddr_o == RTaddr_i.
REQ-015 HazardStall_o SHALL depend only on registered state and the current ID inputs, and SHALL be independent of Stall_i and Flush_i.
REQ-016 Register update SHALL follow this priority at each rising edge:
  - Stall_i = 1: all registers hold;
  - else Flush_i = 1 or HazardStall_o = 1: bubble;
  - else normal load.
REQ-017 On a normal load, every output register SHALL capture its corresponding _i input.
REQ-018 On a bubble, Control_o SHALL load 8'h00, and all data/address/funct registers SHALL load their _i inputs, so that no write or memory access occurs.
REQ-019 Latency SHALL be exactly one cycle from the ID inputs to the EX outputs.
REQ-020 BubbleCnt_o SHALL increment by 1 on each edge on which a bubble is inserted, and SHALL saturate at 16'hFFFF.
REQ-021 When Flush_i and the hazard are both active in the same edge, exactly one bubble SHALL be counted.
REQ-022 While Stall_i = 1, BubbleCnt_o SHALL hold even if Flush_i or HazardStall_o is asserted.
REQ-023 A load writing to $0 (RTaddr_o = 0) SHALL never raise HazardStall_o.
REQ-024 Back-to-back loads SHALL each be checked against the instruction following them; a bubble clears Control_o[2], so a single hazard stalls for exactly one cycle.

Reset
REQ-025 On rst_n_i = 0, all output registers and BubbleCnt_o SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-026 Consequently HazardStall_o SHALL be 0 and PCWrite_o and IFIDWrite_o SHALL be 1 during reset.
REQ-027 Reset asserted mid-stall or mid-bubble SHALL discard all pending state.
REQ-028 The first rising edge after rst_n_i deasserts SHALL perform a normal load.

Verification
REQ-029 Normal load: Control_i = 8'h81, RS1data_i = 32'h5, RDaddr_i = 3 -> after 1 edge, Control_o = 8'h81, RS1data_o = 5, RDaddr_o = 3, HazardStall_o = 0.
REQ-030 Load-use hazard: lw in EX (Control_o = 8'h17, RTaddr_o = 8) and ID RSaddr_i = 8:
  - HazardStall_o = 1 and PCWrite_o = 0 in the same cycle;
  - next edge Control_o = 8'h00 and BubbleCnt_o = 1;
  - following cycle HazardStall_o = 0.
REQ-031 $0 exemption: lw with RTaddr_o = 0 and RSaddr_i = 0 -> HazardStall_o = 0 and no bubble.
REQ-032 Stall priority: Stall_i = 1 with Flush_i = 1 for 3 edges -> all outputs and BubbleCnt_o unchanged. Release Stall_i with Flush_i still 1 -> Control_o = 8'h00 and BubbleCnt_o + 1.
REQ-033 Saturation: preload BubbleCnt_o = 16'hFFFE, then flush for 3 edges -> BubbleCnt_o = 16'hFFFF and it stays there.
REQ-034 Asynchronous reset: drop rst_n_i between clock edges while Control_o = 8'h81 -> Control_o = 0 and BubbleCnt_o = 0 before the next edge.
